query_row_bank_sched: RTL

Write-side scheduler for the query-row double buffer. It takes patch words from the aggregator through a valid/ready handshake and writes them, row by row, into two alternating RAM banks. Each filled bank is handed to the downstream reader with a ready/done handshake. Writing stalls whenever both banks hold unread rows. The block sits between the aggregator output and the double-buffer write port and runs in the wclk domain.

---
 rtl/qrow_sched_pkg.sv | 16 +
 rtl/qrow_bank_tracker.sv | 52 +++++
 rtl/query_row_bank_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/qrow_sched_pkg.sv
// rtl/qrow_sched_pkg.sv - shared types and defaults for the query-row bank scheduler
package qrow_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_FREE = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    typedef logic bank_t;

    localparam int unsigned DEF_ROW_LEN  = 128;
    localparam int unsigned DEF_NUM_ROWS = 16;

endpackage

// File: rtl/qrow_bank_tracker.sv
// rtl/qrow_bank_tracker.sv - full flags of the two banks and the reader's bank pointer
module qrow_bank_tracker
    import qrow_sched_pkg::*;
(
    input  logic       wclk,
    input  logic       wrst_n,
    input  logic       i_set,
    input  bank_t      i_set_bank,
    input  logic       i_release,
    output logic       o_row_ready,
    output bank_t      o_rd_bank,
    output logic       o_both_full,
    output logic [1:0] o_full_nxt
);

    logic [1:0] r_full;
    bank_t      r_rd_bank;
    logic       r_row_ready;
    logic [1:0] w_full_nxt;
    bank_t      w_rd_nxt;

    // A set and a release on the same bank index resolve in favour of the set.
    always_comb begin
        w_full_nxt = r_full;
        w_rd_nxt   = r_rd_bank;
        if (i_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
            w_rd_nxt              = ~r_rd_bank;
        end
        if (i_set) begin
            w_full_nxt[i_set_bank] = 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_full      <= 2'b00;
            r_rd_bank   <= 1'b0;
            r_row_ready <= 1'b0;
        end else begin
            r_full      <= w_full_nxt;
            r_rd_bank   <= w_rd_nxt;
            r_row_ready <= w_full_nxt[w_rd_nxt];
        end
    end

    assign o_row_ready = r_row_ready;
    assign o_rd_bank   = r_rd_bank;
    assign o_both_full = &w_full_nxt;
    assign o_full_nxt  = w_full_nxt;

endmodule

// File: rtl/query_row_bank_sched.sv
// rtl/query_row_bank_sched.sv - write-side row scheduler for the query-row double buffer
// Optional protocol checker: QROW_SCHED_ERR_EN
module query_row_bank_sched
    import qrow_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned ROW_LEN    = DEF_ROW_LEN,
    parameter int unsigned NUM_ROWS   = DEF_NUM_ROWS
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  row_ready,
    output logic                  rd_bank,
    input  logic                  row_done,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);

    localparam int unsigned RW = $clog2(NUM_ROWS + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROW_LEN - 1);
    localparam logic [RW-1:0]         LAST_ROW  = RW'(NUM_ROWS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_in_ready;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_wr_en;
    bank_t                 r_wr_bank;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_word_cnt;
    logic [RW-1:0]         r_row_cnt;
    bank_t                 r_cur_bank;
    logic                  w_in_ready_nxt;
    logic                  w_busy_nxt;
    logic                  w_frame_done_nxt;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_set;
    logic                  w_release;
    logic                  w_row_ready;
    bank_t                 w_rd_bank;
    logic                  w_both_full;
    logic [1:0]            w_full_nxt;

    assign w_xfer    = in_valid && r_in_ready;
    assign w_last    = w_xfer && (r_word_cnt == LAST_ADDR);
    // The bank is marked full when its last write commits, one cycle after acceptance.
    assign w_set     = r_wr_en && (r_wr_addr == LAST_ADDR);
    assign w_release = row_done && w_row_ready;

    qrow_bank_tracker u_tracker (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .i_set       (w_set),
        .i_set_bank  (r_wr_bank),
        .i_release   (w_release),
        .o_row_ready (w_row_ready),
        .o_rd_bank   (w_rd_bank),
        .o_both_full (w_both_full),
        .o_full_nxt  (w_full_nxt)
    );

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (w_last) begin
                    if (r_row_cnt == LAST_ROW) begin
                        w_state_nxt = DRAIN;
                    end else if (w_full_nxt[~r_cur_bank]) begin
                        w_state_nxt = WAIT_FREE;
                    end
                end
            end
            WAIT_FREE: begin
                if (!w_both_full) begin
                    w_state_nxt = FILL;
                end
            end
            DRAIN: begin
                if (w_full_nxt == 2'b00) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready_nxt   = (w_state_nxt == FILL);
        w_busy_nxt       = (w_state_nxt != IDLE);
        w_frame_done_nxt = (r_state == DRAIN) && (w_state_nxt == IDLE);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_in_ready   <= w_in_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_word_cnt <= '0;
            r_row_cnt  <= '0;
            r_cur_bank <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_bank  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (r_state == IDLE && start) begin
                r_row_cnt <= '0;
            end
            if (w_xfer) begin
                r_wr_bank <= r_cur_bank;
                r_wr_addr <= r_word_cnt;
                r_wr_data <= in_data;
            end
            if (w_last) begin
                r_word_cnt <= '0;
                r_row_cnt  <= r_row_cnt + RW'(1);
                r_cur_bank <= ~r_cur_bank;
            end else if (w_xfer) begin
                r_word_cnt <= r_word_cnt + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef QROW_SCHED_ERR_EN
    logic r_err;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_err <= 1'b0;
        end else if ((row_done && !w_row_ready) || (in_valid && r_state == DRAIN)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign wr_en      = r_wr_en;
    assign wr_bank    = r_wr_bank;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign row_ready  = w_row_ready;
    assign rd_bank    = w_rd_bank;

endmodule
